sample_window_shifter: RTL and testbench
========================================

# sample_window_shifter

Parametrised sample-window delay line for the oversampled acquisition path. It accepts one sample per qualified cycle, keeps the last DEPTH samples as a flat window, and tracks window fill level. It provides a registered random-access tap and an optional running window sum. It sits between the sample counter/quantiser and the downstream correlator/averager, and supersedes the fixed, always-shifting window register.

## Interface
- SAMPLES, 128, samples per symbol
- OSF, 8, oversampling factor
- DEPTH, 4, window length in words; legal range 2..64
- Derived word width W = $clog2(SAMPLES*OSF)+1, which is 11 at the defaults
- Derived tap-select width TW = $clog2(DEPTH)
- Clk  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-low reset
- Clear  in  1  synchronous flush of the window, fill level and sum
- InValid  in  1  DataIn is qualified this cycle
- DataIn  in  W  unsigned sample
- TapSel  in  TW  window index to read; 0 is the newest sample
- DataOut  out  W*DEPTH  whole window; word k occupies bits [k*W +: W], and word 0 is the newest
- TapOut  out  W  registered copy of the selected word
- TapValid  out  1  TapOut holds a sample that has been written
- Fill  out  $clog2(DEPTH+1)  number of valid words, saturating at DEPTH
- Full  out  1  Fill == DEPTH
- SumOut  out  W+TW  running sum of the valid words; present only when SAMPLE_WINDOW_SUM_EN is defined

## Operation
- Reset low: all outputs and state go to 0 immediately.
- InValid=1 with Clear=0:
  - window shifts up by one word: word k takes word k-1, word 0 takes DataIn, and word DEPTH-1 is discarded
  - Fill increments, saturating at DEPTH
- InValid=0 with Clear=0: the window and Fill hold, with no shift. This is the key change from the always-shifting predecessor.
- Clear=1: window, Fill and sum go to 0 on that edge; Clear has priority over a simultaneous InValid, and that sample is dropped.
- Full is decoded combinationally from the Fill register.
- Tap read:
  - TapOut(t+1) = word TapSel(t) of the window at t, i.e. the contents before the edge-t update
  - TapValid(t+1) = (TapSel(t) < Fill(t))
- Out-of-range TapSel (≥ DEPTH, possible when DEPTH is not a power of two): TapOut=0 and TapValid=0.
- Clear also zeroes TapOut and TapValid on the same edge.
- All arithmetic is unsigned. No X propagation is allowed: unwritten words read as 0.

## Timing
- Window, Fill and Full update on the edge where InValid is sampled, so the new value is visible one cycle later.
- Tap read has one-cycle latency from TapSel.
- SumOut is registered and updates on the same edge as the window, with no extra latency.
- Back-to-back InValid at full rate is supported indefinitely; there is no stall or backpressure.
- Reset deassertion is synchronised externally; the block only requires Reset to be asynchronous to assert.

## Configuration
- SAMPLE_WINDOW_SUM_EN defined:
  - SumOut port and accumulator are present
  - update rule: Sum ← Sum + DataIn − (Full ? word DEPTH-1 : 0) on each qualified sample
  - Clear zeroes the sum
  - overflow is impossible, since DEPTH·(2^W−1) < 2^(W+TW)
- Not defined: the port, adder and subtractor are absent, and all other behaviour is identical.

## Structure
- Package sample_window_pkg holds:
  - the word-width function W(SAMPLES, OSF)
  - the fill-width and sum-width helper functions
  - the DEPTH legality check constant
- One sub-module, sample_window_sum, holds the incremental accumulator. It is instantiated under SAMPLE_WINDOW_SUM_EN and takes DataIn, the evicted word, InValid, Full and Clear.

## Test plan
All scenarios use the defaults (W=11, DEPTH=4).
- **Reset and fill:** hold Reset low, release, then pulse InValid with 10, 20, 30, 40 → Fill goes 1, 2, 3, 4; Full asserts after the 4th; DataOut words 0..3 = 40, 30, 20, 10.
- **Gapped input:** InValid toggles 1,0,0,1 with DataIn 5 then 7 → the window shifts only twice; words 0, 1 = 7, 5; Fill=2.
- **Eviction and sum:** full window 10, 20, 30, 40, then push 2047 → words = 2047, 40, 30, 20; SumOut = 2137, Fill stays 4.
- **Tap read:**
  - Fill=2, TapSel=3 → next cycle TapValid=0 and TapOut=0
  - TapSel=1 → next cycle TapOut = the older sample and TapValid=1
- **Clear beats InValid:** Clear=1 with InValid=1 and DataIn=99 → window, Fill, SumOut and TapValid are all 0 next cycle; 99 is absent.
- **Async reset mid-stream:** assert Reset low between edges while Full=1 → all outputs are 0 before the next Clk edge, and stay 0 until the first InValid after release.

Source files
------------

// File: rtl/sample_window_pkg.sv
// Shared sizing helpers for the sample window delay line: word width from the
// sampling configuration, fill/tap/sum widths, and the legal DEPTH range.
package sample_window_pkg;

    localparam int MIN_DEPTH = 2;
    localparam int MAX_DEPTH = 64;

    // Width of one sample word: enough for SAMPLES*OSF plus one spare bit.
    function automatic int word_width(input int samples, input int osf);
        return $clog2(samples * osf) + 1;
    endfunction

    // Width of the tap index; index 0 is the newest sample.
    function automatic int tap_width(input int depth);
        return $clog2(depth);
    endfunction

    // Width of the fill counter, which must be able to hold DEPTH itself.
    function automatic int fill_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Width of the running sum: DEPTH*(2^W-1) always fits in W+$clog2(DEPTH) bits.
    function automatic int sum_width(input int w, input int depth);
        return w + $clog2(depth);
    endfunction

    // True when DEPTH lies in the supported range.
    function automatic bit depth_legal(input int depth);
        return (depth >= MIN_DEPTH) && (depth <= MAX_DEPTH);
    endfunction

endpackage

// File: rtl/sample_window_sum.sv
// Incremental window accumulator: adds each accepted sample and subtracts the
// word that falls off the end once the window is full. Only instantiated when
// SAMPLE_WINDOW_SUM_EN is defined.
module sample_window_sum
    import sample_window_pkg::*;
#(
    parameter int W  = 11,
    parameter int SW = 13
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          in_valid,
    input  logic          full,
    input  logic [W-1:0]  data_in,
    input  logic [W-1:0]  evicted,
    output logic [SW-1:0] sum_out
);

    logic [SW-1:0] sum_q;
    logic [SW-1:0] sum_d;

    // Next sum: clear wins, otherwise add the new sample and drop the evicted one.
    always_comb begin
        sum_d = sum_q;
        if (clear) begin
            sum_d = '0;
        end else if (in_valid) begin
            // The evicted word is always part of the current sum, so this never wraps.
            sum_d = sum_q + SW'(data_in) - (full ? SW'(evicted) : '0);
        end
    end

    // Sum register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum_out = sum_q;

endmodule

// File: rtl/sample_window_shifter.sv
// Sample-window delay line: shifts in one sample per InValid cycle, holds when
// idle, tracks fill level and offers a registered random-access tap.
// Optional running window sum is built when SAMPLE_WINDOW_SUM_EN is defined.
module sample_window_shifter
    import sample_window_pkg::*;
#(
    parameter  int SAMPLES = 128,
    parameter  int OSF     = 8,
    parameter  int DEPTH   = 4,
    localparam int W       = word_width(SAMPLES, OSF),
    localparam int TW      = tap_width(DEPTH),
    localparam int FW      = fill_width(DEPTH),
    localparam int SW      = sum_width(W, DEPTH)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Clear,
    input  logic             InValid,
    input  logic [W-1:0]     DataIn,
    input  logic [TW-1:0]    TapSel,
`ifdef SAMPLE_WINDOW_SUM_EN
    output logic [SW-1:0]    SumOut,
`endif
    output logic [W*DEPTH-1:0] DataOut,
    output logic [W-1:0]     TapOut,
    output logic             TapValid,
    output logic [FW-1:0]    Fill,
    output logic             Full
);

    if (!depth_legal(DEPTH)) begin : g_depth_check
        $error("sample_window_shifter: DEPTH must be within %0d..%0d", MIN_DEPTH, MAX_DEPTH);
    end

    logic [W-1:0]  win_q [DEPTH];
    logic [W-1:0]  win_d [DEPTH];
    logic [FW-1:0] fill_q;
    logic [FW-1:0] fill_d;
    logic [W-1:0]  tap_out_q;
    logic [W-1:0]  tap_out_d;
    logic          tap_valid_q;
    logic          tap_valid_d;
    logic          full;

    assign full = (fill_q == FW'(DEPTH));

    // Window and fill next-state: clear, shift on a qualified sample, else hold.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and infers a latch.
        win_d  = win_q;
        fill_d = fill_q;
        if (Clear) begin
            for (int k = 0; k < DEPTH; k++) begin
                win_d[k] = '0;
            end
            fill_d = '0;
        end else if (InValid) begin
            win_d[0] = DataIn;
            for (int k = 1; k < DEPTH; k++) begin
                win_d[k] = win_q[k-1];
            end
            if (!full) begin
                fill_d = fill_q + FW'(1);
            end
        end
    end

    // Tap next-state: select from the pre-update window; unmatched indices read 0.
    always_comb begin
        tap_out_d   = '0;
        tap_valid_d = 1'b0;
        if (!Clear) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (TapSel == TW'(k)) begin
                    tap_out_d = win_q[k];
                end
            end
            // Fill never exceeds DEPTH, so this also rejects out-of-range selects.
            tap_valid_d = (FW'(TapSel) < fill_q);
        end
    end

    // State registers for window, fill level and tap.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            // NOTE: the window storage is reset on purpose so unwritten words read as 0 rather than X.
            for (int k = 0; k < DEPTH; k++) begin
                win_q[k] <= '0;
            end
            fill_q      <= '0;
            tap_out_q   <= '0;
            tap_valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            win_q       <= win_d;
            fill_q      <= fill_d;
            tap_out_q   <= tap_out_d;
            tap_valid_q <= tap_valid_d;
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_flat
        assign DataOut[k*W +: W] = win_q[k];
    end

    assign TapOut   = tap_out_q;
    assign TapValid = tap_valid_q;
    assign Fill     = fill_q;
    assign Full     = full;

`ifdef SAMPLE_WINDOW_SUM_EN
    sample_window_sum #(
        .W  (W),
        .SW (SW)
    ) u_sum (
        .clk      (Clk),
        .rst_n    (Reset),
        .clear    (Clear),
        .in_valid (InValid),
        .full     (full),
        .data_in  (DataIn),
        .evicted  (win_q[DEPTH-1]),
        .sum_out  (SumOut)
    );
`endif

endmodule

// File: tb/tb_sample_window_shifter.sv
// Scoreboard bench for sample_window_shifter at default parameters.
module tb_sample_window_shifter;

    localparam int W     = 11;
    localparam int DEPTH = 4;
    localparam int TW    = 2;
    localparam int FW    = 3;
    localparam int SW    = 13;

    logic             Clk     = 1'b0;
    logic             Reset   = 1'b0;
    logic             Clear   = 1'b0;
    logic             InValid = 1'b0;
    logic [W-1:0]     DataIn  = '0;
    logic [TW-1:0]    TapSel  = '0;
    logic [W*DEPTH-1:0] DataOut;
    logic [W-1:0]     TapOut;
    logic             TapValid;
    logic [FW-1:0]    Fill;
    logic             Full;
`ifdef SAMPLE_WINDOW_SUM_EN
    logic [SW-1:0]    SumOut;
`endif

    sample_window_shifter dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Clear    (Clear),
        .InValid  (InValid),
        .DataIn   (DataIn),
        .TapSel   (TapSel),
`ifdef SAMPLE_WINDOW_SUM_EN
        .SumOut   (SumOut),
`endif
        .DataOut  (DataOut),
        .TapOut   (TapOut),
        .TapValid (TapValid),
        .Fill     (Fill),
        .Full     (Full)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        string         name;
        int            w [DEPTH];
        int            fill;
        int            full;
        int            tap;
        int            tap_v;
        int            sum;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input string name, input int w0, input int w1, input int w2,
                                input int w3, input int fill, input int tap, input int tap_v,
                                input int sum);
        exp_t e;
        e.name  = name;
        e.w[0]  = w0;
        e.w[1]  = w1;
        e.w[2]  = w2;
        e.w[3]  = w3;
        e.fill  = fill;
        e.full  = (fill == DEPTH) ? 1 : 0;
        e.tap   = tap;
        e.tap_v = tap_v;
        e.sum   = sum;
        return e;
    endfunction

    // Drive inputs now and queue the response expected after the next event.
    task automatic drive(input logic iv, input int din, input logic clr, input int tsel,
                         input string name, input int w0, input int w1, input int w2,
                         input int w3, input int fill, input int tap, input int tap_v,
                         input int sum);
        InValid = iv;
        DataIn  = W'(din);
        Clear   = clr;
        TapSel  = TW'(tsel);
        exp_q.push_back(mk(name, w0, w1, w2, w3, fill, tap, tap_v, sum));
    endtask

    task automatic step(input logic iv, input int din, input logic clr, input int tsel,
                        input string name, input int w0, input int w1, input int w2,
                        input int w3, input int fill, input int tap, input int tap_v,
                        input int sum);
        @(negedge Clk);
        drive(iv, din, clr, tsel, name, w0, w1, w2, w3, fill, tap, tap_v, sum);
    endtask

    // Monitor: after each clock edge or reset assertion, pop and compare.
    initial begin
        exp_t e;
        forever begin
            @(posedge Clk or negedge Reset);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                for (int k = 0; k < DEPTH; k++) begin
                    check($sformatf("%s.word%0d", e.name, k), 64'(DataOut[k*W +: W]), 64'(e.w[k]));
                end
                check({e.name, ".fill"},  64'(Fill),     64'(e.fill));
                check({e.name, ".full"},  64'(Full),     64'(e.full));
                check({e.name, ".tap"},   64'(TapOut),   64'(e.tap));
                check({e.name, ".tapv"},  64'(TapValid), 64'(e.tap_v));
`ifdef SAMPLE_WINDOW_SUM_EN
                check({e.name, ".sum"},   64'(SumOut),   64'(e.sum));
`endif
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //    iv din  clr tsel name            w0    w1    w2   w3  fill tap  tv  sum
        // Held in reset: inputs are ignored.
        step(1, 123,  0, 0, "reset0",          0,    0,    0,   0,  0,   0,   0,  0);
        step(1, 123,  0, 1, "reset1",          0,    0,    0,   0,  0,   0,   0,  0);
        @(negedge Clk);
        Reset   = 1'b1;
        InValid = 1'b0;
        TapSel  = '0;

        // Reset and fill.
        step(1, 10,   0, 0, "fill1",           10,   0,    0,   0,  1,   0,   0,  10);
        step(1, 20,   0, 0, "fill2",           20,   10,   0,   0,  2,   10,  1,  30);
        step(1, 30,   0, 1, "fill3",           30,   20,   10,  0,  3,   10,  1,  60);
        step(1, 40,   0, 3, "fill4",           40,   30,   20,  10, 4,   0,   0,  100);
        // Eviction with maximum sample value.
        step(1, 2047, 0, 3, "evict",           2047, 40,   30,  20, 4,   10,  1,  2137);
        step(0, 0,    0, 0, "hold_full",       2047, 40,   30,  20, 4,   2047, 1, 2137);
        // Clear beats a simultaneous sample.
        step(1, 99,   1, 0, "clear",           0,    0,    0,   0,  0,   0,   0,  0);
        // Gapped input.
        step(1, 5,    0, 0, "gap_a",           5,    0,    0,   0,  1,   0,   0,  5);
        step(0, 77,   0, 0, "gap_idle1",       5,    0,    0,   0,  1,   5,   1,  5);
        step(0, 0,    0, 0, "gap_idle2",       5,    0,    0,   0,  1,   5,   1,  5);
        step(1, 7,    0, 3, "gap_b",           7,    5,    0,   0,  2,   0,   0,  12);
        // Tap reads at Fill=2.
        step(0, 0,    0, 3, "tap_sel3",        7,    5,    0,   0,  2,   0,   0,  12);
        step(0, 0,    0, 1, "tap_sel1",        7,    5,    0,   0,  2,   5,   1,  12);
        step(0, 0,    0, 2, "tap_sel2",        7,    5,    0,   0,  2,   0,   0,  12);
        // Refill to full before the asynchronous reset.
        step(1, 100,  0, 0, "refill3",         100,  7,    5,   0,  3,   7,   1,  112);
        step(1, 2000, 0, 2, "refill4",         2000, 100,  7,   5,  4,   5,   1,  2112);
        step(1, 1,    0, 1, "refill_evict",    1,    2000, 100, 7,  4,   100, 1,  2108);

        // Asynchronous reset between edges while full.
        @(negedge Clk);
        InValid = 1'b1;
        DataIn  = W'(55);
        TapSel  = TW'(1);
        #2;
        exp_q.push_back(mk("async_reset", 0, 0, 0, 0, 0, 0, 0, 0));
        Reset = 1'b0;
        step(1, 55,   0, 1, "async_hold",      0,    0,    0,   0,  0,   0,   0,  0);
        @(negedge Clk);
        Reset = 1'b1;
        drive(0, 0,   0, 1, "post_release",    0,    0,    0,   0,  0,   0,   0,  0);
        step(0, 0,    0, 1, "post_idle",       0,    0,    0,   0,  0,   0,   0,  0);
        step(1, 9,    0, 0, "post_first",      9,    0,    0,   0,  1,   0,   0,  9);

        @(negedge Clk);
        InValid = 1'b0;
        Clear   = 1'b0;
        repeat (2) @(negedge Clk);
        check("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
